// File: rtl/data_mem_ctrl_if.sv
// Bundle for the CPU data-memory port and the external word-memory req/ack port.
// The slave modport is the controller. The master modport is the CPU plus memory side.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic [31:0]       cpu_addr;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [31:0]       cpu_wr_data;
  logic [31:0]       cpu_rd_data;
  logic              cpu_valid;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata;
  logic [31:0]       ext_rdata;
  logic              ext_ack;

  modport slave (
    input  cpu_addr, cpu_wr, cpu_rd, cpu_wr_data, ext_rdata, ext_ack,
    output cpu_rd_data, cpu_valid, ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output cpu_addr, cpu_wr, cpu_rd, cpu_wr_data, ext_rdata, ext_ack,
    input  cpu_rd_data, cpu_valid, ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: stores are posted into a write buffer and drained to external memory.
// Loads are served in order behind every buffered store.
module data_mem_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int WB_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_BUSY, RD_DRAIN, RD_BUSY, RD_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wb_addr [WB_DEPTH];
  logic [31:0]       r_wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_head;
  logic [PTR_W:0]    r_count;

  logic              r_ext_req, r_ext_we;
  logic [ADDR_W-1:0] r_ext_addr;
  logic [31:0]       r_ext_wdata, r_cpu_rd_data;
  logic              w_ext_req_nxt, w_ext_we_nxt;
  logic [ADDR_W-1:0] w_ext_addr_nxt;
  logic [31:0]       w_ext_wdata_nxt;
  logic              w_cpu_valid;

  logic              w_full, w_empty, w_last, w_push, w_pop, w_ld, w_ack;
  logic [ADDR_W-1:0] w_cpu_waddr;
  logic              w_unused;

  assign w_cpu_waddr = bus.cpu_addr[ADDR_W+1:2];
  assign w_unused    = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

  assign w_full  = (r_count == (PTR_W+1)'(WB_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_last  = (r_count == (PTR_W+1)'(1));
  assign w_push  = bus.cpu_wr && !w_full;
  assign w_ld    = bus.cpu_rd && !bus.cpu_wr;
  assign w_ack   = r_ext_req && bus.ext_ack;
  assign w_pop   = w_ack && r_ext_we;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: each always_comb assigns defaults first, so no path can leave a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ld)          w_state_nxt = w_empty ? RD_BUSY : RD_DRAIN;
        else if (!w_empty) w_state_nxt = WR_BUSY;
      end
      WR_BUSY:  if (w_ack)           w_state_nxt = IDLE;
      RD_DRAIN: if (w_ack && w_last) w_state_nxt = RD_BUSY;
      RD_BUSY:  if (w_ack)           w_state_nxt = RD_DONE;
      RD_DONE:                       w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // Stores arriving during a drain are younger than the load, so the read goes out after the last older entry.
  assign w_head = (r_state == RD_DRAIN) ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    w_ext_req_nxt   = r_ext_req;
    w_ext_we_nxt    = r_ext_we;
    w_ext_addr_nxt  = r_ext_addr;
    w_ext_wdata_nxt = r_ext_wdata;
    w_cpu_valid     = (r_state == RD_DONE) || (bus.cpu_wr ? !w_full : !bus.cpu_rd);
    if ((r_state == IDLE && !w_empty) || (r_state == RD_DRAIN && w_ack && !w_last)) begin
      w_ext_req_nxt   = 1'b1;
      w_ext_we_nxt    = 1'b1;
      w_ext_addr_nxt  = r_wb_addr[w_head];
      w_ext_wdata_nxt = r_wb_data[w_head];
    end else if ((r_state == IDLE && w_ld) || (r_state == RD_DRAIN && w_ack)) begin
      w_ext_req_nxt  = 1'b1;
      w_ext_we_nxt   = 1'b0;
      w_ext_addr_nxt = w_cpu_waddr;
    end else if (w_ack) begin
      w_ext_req_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_req     <= 1'b0;
      r_ext_we      <= 1'b0;
      r_ext_addr    <= '0;
      r_ext_wdata   <= '0;
      r_cpu_rd_data <= '0;
    end else begin
      r_ext_req   <= w_ext_req_nxt;
      r_ext_we    <= w_ext_we_nxt;
      r_ext_addr  <= w_ext_addr_nxt;
      r_ext_wdata <= w_ext_wdata_nxt;
      if (r_state == RD_BUSY && w_ack) r_cpu_rd_data <= bus.ext_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // NOTE: buffer storage has no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= w_cpu_waddr;
      r_wb_data[r_wr_ptr] <= bus.cpu_wr_data;
    end
  end

  assign bus.cpu_valid   = w_cpu_valid;
  assign bus.cpu_rd_data = r_cpu_rd_data;
  assign bus.ext_req     = r_ext_req;
  assign bus.ext_we      = r_ext_we;
  assign bus.ext_addr    = r_ext_addr;
  assign bus.ext_wdata   = r_ext_wdata;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: drivers queue expected ext accesses and load data,
// while a negedge monitor compares them against what the DUT presents.
module tb_data_mem_ctrl;
  localparam int ADDR_W   = 14;
  localparam int WB_DEPTH = 4;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } ext_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ext_t        exp_ext[$];
  logic [31:0] exp_ld[$];
  logic [31:0] mem [int];
  int n_cmp = 0, n_err = 0, cyc = 0;
  int ack_delay = 0, wcnt = 0, first_ack_cyc = -1, acc_cyc = 0;
  bit rand_delay = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // External memory responder with a programmable ack delay (0 = ack in the req-rise cycle).
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.ext_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (bus.ext_ack) begin
        bus.ext_ack = 1'b0;
        wcnt = 0;
        if (rand_delay) ack_delay = $urandom_range(0, 5);
      end
      if (bus.ext_req) begin
        if (wcnt >= ack_delay) begin
          bus.ext_ack = 1'b1;
          if (bus.ext_we) mem[int'(bus.ext_addr)] = bus.ext_wdata;
          else bus.ext_rdata = mem.exists(int'(bus.ext_addr)) ? mem[int'(bus.ext_addr)] : 32'h0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  logic              p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [31:0]       p_wdata = '0;
  ext_t              m_e;
  logic [31:0]       m_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_req = 1'b0;
    end else begin
      assert (!(bus.cpu_wr && bus.cpu_rd));
      check("count_bound", 32'(dut.r_count <= WB_DEPTH), 32'd1);
      if (p_req && !p_ack) begin
        check("hold_req", 32'(bus.ext_req), 32'd1);
        check("hold_we", 32'(bus.ext_we), 32'(p_we));
        check("hold_addr", 32'(bus.ext_addr), 32'(p_addr));
        check("hold_wdata", bus.ext_wdata, p_wdata);
      end
      if (bus.ext_req && bus.ext_ack) begin
        if (exp_ext.size() == 0) begin
          check("ext_unexpected", 32'(exp_ext.size()), 32'd1);
        end else begin
          m_e = exp_ext.pop_front();
          check("ext_we", 32'(bus.ext_we), 32'(m_e.we));
          check("ext_addr", 32'(bus.ext_addr), 32'(m_e.addr));
          if (m_e.we) check("ext_wdata", bus.ext_wdata, m_e.wdata);
          if (m_e.we && first_ack_cyc < 0) first_ack_cyc = cyc;
        end
      end
      if (bus.cpu_rd && bus.cpu_valid) begin
        if (exp_ld.size() == 0) begin
          check("load_unexpected", 32'(exp_ld.size()), 32'd1);
        end else begin
          m_d = exp_ld.pop_front();
          check("load_data", bus.cpu_rd_data, m_d);
        end
      end
      p_req = bus.ext_req; p_ack = bus.ext_ack; p_we = bus.ext_we;
      p_addr = bus.ext_addr; p_wdata = bus.ext_wdata;
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int waited);
    ext_t e;
    e.we = 1'b1; e.addr = a[ADDR_W+1:2]; e.wdata = d;
    exp_ext.push_back(e);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_wr_data = d;
    waited = 0;
    @(negedge clk);
    while (!bus.cpu_valid && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("store_accept", 32'(bus.cpu_valid), 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input bit hold, output int lat);
    ext_t e;
    e.we = 1'b0; e.addr = a[ADDR_W+1:2]; e.wdata = '0;
    exp_ext.push_back(e);
    exp_ld.push_back(d);
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    lat = 1;
    @(negedge clk);
    while (!bus.cpu_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check("load_done", 32'(bus.cpu_valid), 32'd1);
    @(posedge clk); #1;
    if (!hold) bus.cpu_rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_ext.size() != 0 || bus.ext_req) && n < 500);
    check({tag, "_drain"}, 32'(exp_ext.size() == 0 && !bus.ext_req), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, lat2, n;
    bus.cpu_addr = '0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr_data = '0;
    bus.ext_ack = 1'b0; bus.ext_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ext_req", 32'(bus.ext_req), 32'd0);
    check("rst_ext_we", 32'(bus.ext_we), 32'd0);
    check("rst_ext_addr", 32'(bus.ext_addr), 32'd0);
    check("rst_ext_wdata", bus.ext_wdata, 32'd0);
    check("rst_rd_data", bus.cpu_rd_data, 32'd0);
    check("rst_cpu_valid", 32'(bus.cpu_valid), 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: reset in the middle of a write wait
    ack_delay = 10;
    store(32'h100, 32'hAAAA5555, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ext_req && n < 10);
    check("t1_req_seen", 32'(bus.ext_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("t1_req_drop", 32'(bus.ext_req), 32'd0);
    exp_ext.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_cpu_valid", 32'(bus.cpu_valid), 32'd1);
    check("t1_count", 32'(dut.r_count), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_no_reissue", 32'(bus.ext_req), 32'd0);
    @(posedge clk); #1;

    // T2: four posted stores, fifth stalls until the cycle after the first ack
    ack_delay = 3;
    first_ack_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'(i + 1), w);
      check("t2_posted", 32'(w), 32'd0);
    end
    store(32'h20, 32'd5, w);
    check("t2_stall_release", 32'(acc_cyc), 32'(first_ack_cyc + 1));
    drain("t2");

    // T3: store then immediate load of the same word
    ack_delay = 1;
    store(32'h40, 32'hDEADBEEF, w);
    load(32'h40, 32'hDEADBEEF, 1'b0, lat);
    drain("t3");

    // T4: minimum load latency with ack in the req-rise cycle
    ack_delay = 0;
    mem[32'h20] = 32'h12345678;
    load(32'h80, 32'h12345678, 1'b0, lat);
    check("t4_latency", 32'(lat), 32'd3);
    repeat (3) @(negedge clk);
    check("t4_rd_hold", bus.cpu_rd_data, 32'h12345678);
    @(posedge clk); #1;

    // T5: pointer wrap with random data and random ack delays
    rand_delay = 1'b1;
    ack_delay = $urandom_range(0, 5);
    for (int i = 0; i < 3 * WB_DEPTH + 1; i++) begin
      store({16'h0, 14'($urandom_range(0, 16383)), 2'b00}, $urandom, w);
    end
    drain("t5");
    check("t5_final_count", 32'(dut.r_count), 32'd0);
    rand_delay = 1'b0;

    // T6: back-to-back loads with cpu_rd held through cpu_valid
    ack_delay = 1;
    mem[32'h30] = 32'hCAFE0001;
    mem[32'h31] = 32'hCAFE0002;
    load(32'hC0, 32'hCAFE0001, 1'b1, lat);
    load(32'hC4, 32'hCAFE0002, 1'b0, lat2);
    check("t6_lat_first", 32'(lat), 32'd4);
    check("t6_lat_second", 32'(lat2), 32'd4);
    drain("t6");
    check("final_ext_queue", 32'(exp_ext.size()), 32'd0);
    check("final_load_queue", 32'(exp_ld.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
